// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and
// oversampling defaults used by uart_rx and its sub-module.
package uart_rx_pkg;

  localparam int UART_OVS = 16;
  localparam int UART_MID = 7;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync_edge.sv
// Two-flop synchronizer for the serial line plus a rising-edge detector that
// turns the slow baud16 clock into single-cycle ticks in the clk domain.
module uart_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic rxd,
  input  logic baud16_clk,
  output logic rxd_s,
  output logic tick
);

  logic rxd_meta_q, rxd_meta_d;
  logic rxd_s_q, rxd_s_d;
  logic baud16_q, baud16_d;

  always_comb begin
    rxd_meta_d = rxd;
    rxd_s_d    = rxd_meta_q;
    baud16_d   = baud16_clk;
  end

  // Line resets to its idle level; baud16_q resets high so a high baud clock
  // at reset release does not produce a spurious tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      baud16_q   <= 1'b1;
    end else begin
      rxd_meta_q <= rxd_meta_d;
      rxd_s_q    <= rxd_s_d;
      baud16_q   <= baud16_d;
    end
  end

  assign rxd_s = rxd_s_q;
  assign tick  = baud16_clk & ~baud16_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, 8 data bits LSB first, optional even/odd parity,
// 1 stop bit, sampled from an oversampling tick derived from baud16_clk.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int OVS = UART_OVS,
  parameter int MID = UART_MID
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud16_clk,
  input  logic       rx_en,
  input  logic       no_parity,
  input  logic       ev_parity,
  input  logic       rxd,
  output logic [7:0] rxd_out,
  output logic       rx_ok,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int TW = $clog2(OVS);
  localparam logic [TW-1:0] TCNT_MID  = TW'(MID);
  localparam logic [TW-1:0] TCNT_LAST = TW'(OVS - 1);

  logic rxd_s, tick;

  rx_state_e state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d, tcnt_inc;
  logic [2:0] bcnt_q, bcnt_d;
  logic [7:0] shift_q, shift_d;
  logic cfg_np_q, cfg_np_d;
  logic cfg_ev_q, cfg_ev_d;
  logic par_bad_q, par_bad_d;
  logic wait_high_q, wait_high_d;
  logic [7:0] rxd_out_q, rxd_out_d;
  logic parity_err_q, parity_err_d;
  logic frame_err_q, frame_err_d;
  logic rx_ok_q, rx_ok_d;
  logic tcnt_last;

  uart_sync_edge u_sync_edge (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .baud16_clk (baud16_clk),
    .rxd_s      (rxd_s),
    .tick       (tick)
  );

  assign tcnt_last = (tcnt_q == TCNT_LAST);
  assign tcnt_inc  = tcnt_last ? '0 : tcnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RX_IDLE;
      tcnt_q       <= '0;
      bcnt_q       <= '0;
      shift_q      <= '0;
      cfg_np_q     <= 1'b0;
      cfg_ev_q     <= 1'b0;
      par_bad_q    <= 1'b0;
      wait_high_q  <= 1'b0;
      rxd_out_q    <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_ok_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      tcnt_q       <= tcnt_d;
      bcnt_q       <= bcnt_d;
      shift_q      <= shift_d;
      cfg_np_q     <= cfg_np_d;
      cfg_ev_q     <= cfg_ev_d;
      par_bad_q    <= par_bad_d;
      wait_high_q  <= wait_high_d;
      rxd_out_q    <= rxd_out_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      rx_ok_q      <= rx_ok_d;
    end
  end

  // After a low stop bit the line must be seen high before a new start bit counts.
  always_comb begin
    state_d = state_q;
    if (!rx_en) begin
      state_d = RX_IDLE;
    end else if (tick) begin
      case (state_q)
        RX_IDLE:   if (!wait_high_q && !rxd_s) state_d = RX_START;
        RX_START:  if (tcnt_q == TCNT_MID) state_d = rxd_s ? RX_IDLE : RX_DATA;
        RX_DATA:   if (tcnt_last && bcnt_q == 3'd7) state_d = cfg_np_q ? RX_STOP : RX_PARITY;
        RX_PARITY: if (tcnt_last) state_d = RX_STOP;
        RX_STOP:   if (tcnt_last) state_d = RX_IDLE;
        default:   state_d = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    tcnt_d       = tcnt_q;
    bcnt_d       = bcnt_q;
    shift_d      = shift_q;
    cfg_np_d     = cfg_np_q;
    cfg_ev_d     = cfg_ev_q;
    par_bad_d    = par_bad_q;
    wait_high_d  = wait_high_q;
    rxd_out_d    = rxd_out_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    rx_ok_d      = 1'b0;
    if (!rx_en) begin
      tcnt_d      = '0;
      bcnt_d      = '0;
      shift_d     = '0;
      wait_high_d = 1'b0;
    end else if (tick) begin
      case (state_q)
        RX_IDLE: begin
          tcnt_d = '0;
          if (rxd_s) wait_high_d = 1'b0;
        end
        RX_START: begin
          tcnt_d = tcnt_inc;
          if (tcnt_q == TCNT_MID) begin
            tcnt_d = '0;
            if (!rxd_s) begin
              bcnt_d    = '0;
              cfg_np_d  = no_parity;
              cfg_ev_d  = ev_parity;
              par_bad_d = 1'b0;
            end
          end
        end
        RX_DATA: begin
          tcnt_d = tcnt_inc;
          if (tcnt_last) begin
            shift_d[bcnt_q] = rxd_s;
            bcnt_d          = bcnt_q + 3'd1;
          end
        end
        RX_PARITY: begin
          tcnt_d = tcnt_inc;
          if (tcnt_last) par_bad_d = rxd_s ^ (cfg_ev_q ? ^shift_q : ~^shift_q);
        end
        RX_STOP: begin
          tcnt_d = tcnt_inc;
          if (tcnt_last) begin
            rxd_out_d    = shift_q;
            parity_err_d = ~cfg_np_q & par_bad_q;
            frame_err_d  = ~rxd_s;
            wait_high_d  = ~rxd_s;
            rx_ok_d      = 1'b1;
          end
        end
        default: tcnt_d = '0;
      endcase
    end
  end

  assign rxd_out    = rxd_out_q;
  assign rx_ok      = rx_ok_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized frames
// compared against a bit-counting reference model of the frame format.
module tb_uart_rx;

  localparam int BIT_TICKS = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud16_clk = 1'b0;
  logic       rx_en = 1'b0;
  logic       no_parity = 1'b1;
  logic       ev_parity = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] rxd_out;
  logic       rx_ok;
  logic       parity_err;
  logic       frame_err;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    longint     t;
  } obs_t;

  obs_t obs_q[$];
  logic prev_ok = 1'b0;

  uart_rx #(.OVS(16), .MID(7)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .baud16_clk (baud16_clk),
    .rx_en      (rx_en),
    .no_parity  (no_parity),
    .ev_parity  (ev_parity),
    .rxd        (rxd),
    .rxd_out    (rxd_out),
    .rx_ok      (rx_ok),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;
  always #40 baud16_clk = ~baud16_clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every rx_ok pulse is recorded with the outputs seen in that cycle.
  always @(negedge clk) begin
    if (rx_ok) begin
      checkOutput("rx_ok_single_cycle", {31'd0, prev_ok}, 32'd0);
      obs_q.push_back('{d: rxd_out, pe: parity_err, fe: frame_err, t: $time});
    end
    prev_ok <= rx_ok;
  end

  function automatic logic modelParityErr(input logic [7:0] d, input logic np,
                                          input logic ev, input logic pbit);
    int ones;
    ones = $countones(d) + int'(pbit);
    if (np) return 1'b0;
    return ev ? (ones % 2 == 1) : (ones % 2 == 0);
  endfunction

  task automatic waitTicks(input int n);
    repeat (n) @(negedge baud16_clk);
  endtask

  task automatic sendBit(input logic b);
    rxd = b;
    waitTicks(BIT_TICKS);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic np, input logic ev,
                               input logic pbit, input logic stopb, input logic flip_cfg);
    no_parity = np;
    ev_parity = ev;
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) begin
      sendBit(d[i]);
      if (flip_cfg && i == 2) begin
        no_parity = 1'($urandom_range(0, 1));
        ev_parity = 1'($urandom_range(0, 1));
      end
    end
    if (!np) sendBit(pbit);
    sendBit(stopb);
  endtask

  task automatic checkFrame(input string tag, input logic [7:0] d, input logic pe, input logic fe);
    int waited;
    obs_t o;
    waited = 0;
    while (obs_q.size() == 0 && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (obs_q.size() == 0) begin
      checkOutput({tag, "_rx_ok_timeout"}, 32'd0, 32'd1);
      return;
    end
    o = obs_q.pop_front();
    checkOutput({tag, "_data"}, {24'd0, o.d}, {24'd0, d});
    checkOutput({tag, "_parity_err"}, {31'd0, o.pe}, {31'd0, pe});
    checkOutput({tag, "_frame_err"}, {31'd0, o.fe}, {31'd0, fe});
    checkOutput({tag, "_extra_pulses"}, obs_q.size(), 32'd0);
  endtask

  initial begin
    obs_t a;
    obs_t b;
    logic [7:0] d;
    logic np, ev, pbit, stopb;

    waitTicks(3);
    #3;
    checkOutput("reset_rxd_out", {24'd0, rxd_out}, 32'd0);
    checkOutput("reset_rx_ok", {31'd0, rx_ok}, 32'd0);
    checkOutput("reset_parity_err", {31'd0, parity_err}, 32'd0);
    checkOutput("reset_frame_err", {31'd0, frame_err}, 32'd0);
    rst_n = 1'b1;
    rx_en = 1'b1;
    waitTicks(4);

    applyStimulus(8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    checkFrame("even_a5", 8'hA5, modelParityErr(8'hA5, 1'b0, 1'b1, 1'b0), 1'b0);
    rxd = 1'b1;
    waitTicks(4);

    applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkFrame("odd_3c_badpar", 8'h3C, modelParityErr(8'h3C, 1'b0, 1'b0, 1'b0), 1'b0);
    rxd = 1'b1;
    waitTicks(4);

    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    rxd = 1'b1;
    waitTicks(4);
    checkOutput("b2b_count", obs_q.size(), 32'd2);
    if (obs_q.size() >= 2) begin
      a = obs_q.pop_front();
      b = obs_q.pop_front();
      checkOutput("b2b_first", {24'd0, a.d}, 32'h00);
      checkOutput("b2b_second", {24'd0, b.d}, 32'hFF);
      checkOutput("b2b_spacing", 32'(b.t - a.t), 32'(160 * 80));
    end
    obs_q.delete();

    rxd = 1'b0;
    waitTicks(4);
    rxd = 1'b1;
    waitTicks(24);
    checkOutput("glitch_no_rx_ok", obs_q.size(), 32'd0);
    checkOutput("glitch_rxd_out_held", {24'd0, rxd_out}, 32'hFF);
    checkOutput("glitch_frame_err_held", {31'd0, frame_err}, 32'd0);
    applyStimulus(8'hC6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkFrame("after_glitch", 8'hC6, 1'b0, 1'b0);
    rxd = 1'b1;
    waitTicks(4);

    applyStimulus(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    waitTicks(40);
    checkFrame("stop_low_55", 8'h55, 1'b0, 1'b1);
    rxd = 1'b1;
    waitTicks(4);
    applyStimulus(8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    checkFrame("after_break", 8'h5A, modelParityErr(8'h5A, 1'b0, 1'b1, 1'b0), 1'b0);
    rxd = 1'b1;
    waitTicks(4);

    no_parity = 1'b1;
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b1);
    sendBit(1'b0);
    rx_en = 1'b0;
    rxd = 1'b1;
    waitTicks(8);
    checkOutput("en_low_no_rx_ok", obs_q.size(), 32'd0);
    checkOutput("en_low_rxd_out_held", {24'd0, rxd_out}, 32'h5A);
    rx_en = 1'b1;
    waitTicks(4);
    applyStimulus(8'h81, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkFrame("reenable_81", 8'h81, 1'b0, 1'b0);
    rxd = 1'b1;
    waitTicks(4);

    for (int n = 0; n < 16; n++) begin
      d     = 8'($urandom_range(0, 255));
      np    = 1'($urandom_range(0, 1));
      ev    = 1'($urandom_range(0, 1));
      pbit  = 1'($urandom_range(0, 1));
      stopb = ($urandom_range(0, 4) != 0);
      applyStimulus(d, np, ev, pbit, stopb, 1'($urandom_range(0, 1)));
      checkFrame("random", d, modelParityErr(d, np, ev, pbit), ~stopb);
      rxd = 1'b1;
      waitTicks(stopb ? $urandom_range(0, 6) : $urandom_range(2, 8));
    end

    applyStimulus(8'h96, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkFrame("pre_reset_96", 8'h96, modelParityErr(8'h96, 1'b0, 1'b1, 1'b1), 1'b1);
    rxd = 1'b1;
    waitTicks(4);
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b0);
    rst_n = 1'b0;
    #3;
    checkOutput("midreset_rxd_out", {24'd0, rxd_out}, 32'd0);
    checkOutput("midreset_rx_ok", {31'd0, rx_ok}, 32'd0);
    checkOutput("midreset_parity_err", {31'd0, parity_err}, 32'd0);
    checkOutput("midreset_frame_err", {31'd0, frame_err}, 32'd0);
    rxd = 1'b1;
    waitTicks(4);
    rst_n = 1'b1;
    waitTicks(4);
    checkOutput("midreset_no_rx_ok", obs_q.size(), 32'd0);
    applyStimulus(8'h7E, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkFrame("after_reset_7e", 8'h7E, modelParityErr(8'h7E, 1'b0, 1'b0, 1'b1), 1'b0);
    rxd = 1'b1;
    waitTicks(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
